// File: rtl/votador_pkg.sv
// Shared constants and types for the three-voter majority block.
package votador_pkg;

  localparam int unsigned N_VOTERS        = 3;
  localparam int unsigned TALLY_W_DEFAULT = 8;
  localparam int unsigned CNT_W           = 2;

  typedef logic [N_VOTERS-1:0] ballot_t;

endpackage : votador_pkg

// File: rtl/majority3.sv
// Combinational decode of one three-voter ballot: majority, popcount, unanimity, dissenter.
module majority3
  import votador_pkg::*;
(
  input  ballot_t             v,
  output logic                maj_c,
  output logic [CNT_W-1:0]    yes_cnt_c,
  output logic                unanimous_c,
  output ballot_t             dissent_c
);

  always_comb begin
    yes_cnt_c   = CNT_W'(v[0]) + CNT_W'(v[1]) + CNT_W'(v[2]);
    maj_c       = yes_cnt_c[1];
    unanimous_c = (v == '0) || (v == '1);
    dissent_c   = '0;
    // With three voters a split vote has exactly one bit off the majority.
    if (!unanimous_c) begin
      dissent_c = v ^ {N_VOTERS{maj_c}};
    end
  end

endmodule : majority3

// File: rtl/votador.sv
// Registered three-voter majority decision with a saturating count of yes decisions.
module votador
  import votador_pkg::*;
#(
  parameter int unsigned TALLY_W = TALLY_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  ballot_t            V,
  output logic               R,
  output logic [CNT_W-1:0]   yes_cnt,
  output logic               unanimous,
  output ballot_t            dissent,
  output logic [TALLY_W-1:0] tally
);

  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

  logic             maj_c;
  logic [CNT_W-1:0] yes_cnt_c;
  logic             unanimous_c;
  ballot_t          dissent_c;

  logic               r_d, r_q;
  logic [CNT_W-1:0]   yes_cnt_d, yes_cnt_q;
  logic               unanimous_d, unanimous_q;
  ballot_t            dissent_d, dissent_q;
  logic [TALLY_W-1:0] tally_d, tally_q;

  majority3 u_majority3 (
    .v           (V),
    .maj_c       (maj_c),
    .yes_cnt_c   (yes_cnt_c),
    .unanimous_c (unanimous_c),
    .dissent_c   (dissent_c)
  );

  // Next-state: capture the decode and bump the tally on a yes decision, holding at max.
  always_comb begin
    r_d         = maj_c;
    yes_cnt_d   = yes_cnt_c;
    unanimous_d = unanimous_c;
    dissent_d   = dissent_c;
    tally_d     = tally_q;
    if (maj_c && (tally_q != TALLY_MAX)) begin
      tally_d = tally_q + TALLY_W'(1);
    end
  end

  // Reset state mirrors an all-zero vote, which is unanimous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= 1'b0;
      yes_cnt_q   <= '0;
      unanimous_q <= 1'b1;
      dissent_q   <= '0;
      tally_q     <= '0;
    end else begin
      r_q         <= r_d;
      yes_cnt_q   <= yes_cnt_d;
      unanimous_q <= unanimous_d;
      dissent_q   <= dissent_d;
      tally_q     <= tally_d;
    end
  end

  assign R         = r_q;
  assign yes_cnt   = yes_cnt_q;
  assign unanimous = unanimous_q;
  assign dissent   = dissent_q;
  assign tally     = tally_q;

endmodule : votador

// File: tb/tb_votador.sv
// Scoreboard bench for votador: default-width and 2-bit-tally instances share stimulus.
module tb_votador;

  logic       clk;
  logic       rst;
  logic [2:0] V;

  logic       r1, r2;
  logic [1:0] yc1, yc2;
  logic       un1, un2;
  logic [2:0] dis1, dis2;
  logic [7:0] tally8;
  logic [1:0] tally2;

  votador u_dut (
    .clk(clk), .rst(rst), .V(V), .R(r1), .yes_cnt(yc1),
    .unanimous(un1), .dissent(dis1), .tally(tally8)
  );

  votador #(.TALLY_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .V(V), .R(r2), .yes_cnt(yc2),
    .unanimous(un2), .dissent(dis2), .tally(tally2)
  );

  typedef struct {
    logic [2:0] v;
    logic       r;
    logic [1:0] yc;
    logic       un;
    logic [2:0] dis;
    int         t8;
    int         t2;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   m_t8   = 0;
  int   m_t2   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: counting ballots directly, no notion of the RTL structure.
  function automatic exp_t model(input logic [2:0] v);
    exp_t e;
    int   yes = 0;
    for (int i = 0; i < 3; i++) if (v[i]) yes++;
    e.v   = v;
    e.r   = (yes >= 2);
    e.yc  = 2'(yes);
    e.un  = (yes == 0) || (yes == 3);
    e.dis = 3'b000;
    for (int i = 0; i < 3; i++)
      if (!e.un && (v[i] != e.r)) e.dis[i] = 1'b1;
    if (e.r) begin
      if (m_t8 < 255) m_t8++;
      if (m_t2 < 3)   m_t2++;
    end
    e.t8 = m_t8;
    e.t2 = m_t2;
    return e;
  endfunction

  // Drive one vote (called at a falling edge), returns at the next falling edge.
  task automatic apply(input logic [2:0] v);
    V = v;
    exp_q.push_back(model(v));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".R"},       32'(r1),     32'd0);
    chk({tag, ".yes_cnt"}, 32'(yc1),    32'd0);
    chk({tag, ".unan"},    32'(un1),    32'd1);
    chk({tag, ".dissent"}, 32'(dis1),   32'd0);
    chk({tag, ".tally8"},  32'(tally8), 32'd0);
    chk({tag, ".tally2"},  32'(tally2), 32'd0);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    m_t8 = 0;
    m_t2 = 0;
    #1;
    chk_reset_vals("rst_imm");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: outputs refresh every rising edge; pop one expectation per edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("mon.R v=%b", e.v),       32'(r1),     32'(e.r));
      chk($sformatf("mon.yes_cnt v=%b", e.v), 32'(yc1),    32'(e.yc));
      chk($sformatf("mon.unan v=%b", e.v),    32'(un1),    32'(e.un));
      chk($sformatf("mon.dissent v=%b", e.v), 32'(dis1),   32'(e.dis));
      chk($sformatf("mon.tally8 v=%b", e.v),  32'(tally8), 32'(e.t8));
      chk($sformatf("mon.tally2 v=%b", e.v),  32'(tally2), 32'(e.t2));
      chk($sformatf("mon.R2 v=%b", e.v),      32'(r2),     32'(e.r));
    end
  end

  logic [2:0] r_tab  [8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1};
  logic [1:0] yc_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
  int         sat_tab[6] = '{1, 2, 3, 3, 3, 3};
  logic [2:0] dv_tab [5] = '{3'b110, 3'b101, 3'b011, 3'b000, 3'b111};
  logic [2:0] dd_tab [5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};

  initial begin
    rst = 1'b1;
    V   = 3'b000;
    @(negedge clk);
    do_reset();

    // Reset sweep, run twice for the tally total.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        apply(3'(i));
        chk($sformatf("sweep.R v=%0d", i),       32'(r1),  32'(r_tab[i]));
        chk($sformatf("sweep.yes_cnt v=%0d", i), 32'(yc1), 32'(yc_tab[i]));
      end
    end
    chk("sweep.tally8", 32'(tally8), 32'd8);

    // Dissent decode.
    for (int i = 0; i < 5; i++) begin
      apply(dv_tab[i]);
      chk($sformatf("dissent v=%b", dv_tab[i]), 32'(dis1), 32'(dd_tab[i]));
      chk($sformatf("unan v=%b", dv_tab[i]), 32'(un1),
          32'((dv_tab[i] == 3'b000) || (dv_tab[i] == 3'b111)));
    end

    // Saturation of the 2-bit tally, then reset while saturated.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(3'b111);
      chk($sformatf("sat.tally2 step%0d", i), 32'(tally2), 32'(sat_tab[i]));
    end

    // Asynchronous reset between edges with tally at 5.
    do_reset();
    for (int i = 0; i < 5; i++) apply(3'b111);
    chk("async.pre_tally8", 32'(tally8), 32'd5);
    #2;
    rst  = 1'b1;
    m_t8 = 0;
    m_t2 = 0;
    #1;
    chk("async.tally8", 32'(tally8), 32'd0);
    chk("async.R",      32'(r1),     32'd0);

    // Reset release with yes votes held throughout.
    V = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("rel.R_in_rst", 32'(r1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.R_pre_edge", 32'(r1), 32'd0);
    apply(3'b111);
    chk("rel.R_post_edge", 32'(r1), 32'd1);

    // Random votes, long enough to saturate the 8-bit tally.
    for (int i = 0; i < 700; i++) apply(3'($urandom_range(0, 7)));
    chk("rand.tally8_sat", 32'(tally8), 32'd255);

    repeat (2) @(posedge clk);
    chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_votador

// File: doc/votador.md
VOTADOR -- requirements
Module: votador

Interface
REQ-001 The block SHALL have parameter TALLY_W, default 8, giving the width of the decision tally counter; the legal range SHALL be 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit; it is the single clock and all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; rst SHALL be an asynchronous, active-high reset.
REQ-004 The block SHALL have port V, input, 3 bits; each bit is one voter's ballot, where 1 means yes.
REQ-005 The block SHALL have port R, output, 1 bit; it is the registered majority decision.
REQ-006 The block SHALL have port yes_cnt, output, 2 bits; it is the registered count of yes ballots, saturated at 3.
REQ-007 The block SHALL have port unanimous, output, 1 bit; it is registered and is 1 when all three ballots are equal.
REQ-008 The block SHALL have port dissent, output, 3 bits; it is registered and one-hot, marking the single voter that disagrees with the majority, or is 0 when the vote is unanimous.
REQ-009 The block SHALL have port tally, output, TALLY_W bits; it is the registered, saturating count of cycles on which the decision was yes.

Function
REQ-010 R SHALL be 1 exactly when at least two of V[2:0] are 1, giving R = 0,0,0,1,0,1,1,1 for V = 0..7.
REQ-011 All outputs SHALL have a latency of 1 cycle: the value sampled on V at rising edge n SHALL appear on the outputs immediately after edge n.
REQ-012 yes_cnt SHALL equal the popcount of V, giving values 0..3.
REQ-013 unanimous SHALL be 1 for V = 3'b000 and V = 3'b111, and 0 for every other value.
REQ-014 dissent SHALL be set as follows:
- dissent[i] = 1 when V[i] differs from the majority and the vote is not unanimous.
- At most one dissent bit SHALL be set at any time.
REQ-015 tally SHALL increment by 1 on every edge where the newly computed majority is 1.
REQ-016 tally SHALL saturate at 2^TALLY_W - 1 and SHALL never wrap.
REQ-017 V SHALL be treated as a sampled synchronous input; the block SHALL not accept any handshake, and every clock edge SHALL be a valid vote.
REQ-018 Combinational decode SHALL depend only on the current V; there SHALL be no hysteresis.

Reset
REQ-019 While rst = 1, the outputs SHALL be held as follows:
- R = 0, yes_cnt = 0, dissent = 0, tally = 0.
- unanimous = 1, consistent with an all-zero vote.
REQ-020 Reset SHALL take effect immediately, without waiting for a clock edge.
REQ-021 The first update after rst deasserts SHALL reflect V sampled at the first rising edge that has rst = 0.
REQ-022 Asserting reset in the middle of operation SHALL clear tally, even when tally is saturated.

Structure
REQ-023 A shared package votador_pkg SHALL hold the following:
- the voter count constant N_VOTERS = 3;
- the ballot typedef ballot_t = logic [2:0];
- the default tally width.
REQ-024 One combinational sub-module, majority3, SHALL compute majority, popcount, unanimous and dissent from V.
REQ-025 The top level SHALL register the outputs of majority3 and SHALL contain the saturating tally counter.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset sweep: assert rst, then release it and sweep V = 0..7, one value per clock; R SHALL read 0,0,0,1,0,1,1,1 and yes_cnt SHALL read 0,1,1,2,1,2,2,3, each one cycle after the matching V.
- Dissent decode: V = 3'b110 SHALL give dissent = 3'b001; 3'b101 SHALL give 3'b010; 3'b011 SHALL give 3'b100; 3'b000 and 3'b111 SHALL give dissent = 0 with unanimous = 1.
- Tally count: two full sweeps of 0..7 after reset SHALL leave tally = 8.
- Tally saturation: with TALLY_W = 2, holding V = 3'b111 for 6 cycles SHALL make tally read 1,2,3,3,3,3.
- Asynchronous reset: asserting rst between clock edges while tally = 5 SHALL immediately force tally = 0 and R = 0.
- Reset release: with V = 3'b111 held through reset release, R SHALL stay 0 until the first post-release edge and SHALL then read 1.
